// File: rtl/oclib_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, and queues bytes in a
// small internal FIFO presented as a valid/ready stream.
module oclib_uart_rx #(
  parameter int unsigned ClockHz    = 100_000_000,
  parameter int unsigned Baud       = 115_200,
  parameter int unsigned BaudCycles = ClockHz / Baud,
  parameter int unsigned FifoDepth  = 32,
  parameter int unsigned SyncCycles = 3
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       framingError,
  output logic       overflow
);

  localparam int unsigned CntW = $clog2(BaudCycles);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned OccW = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] CntBitLast  = CntW'(BaudCycles - 1);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(BaudCycles / 2 - 1);
  localparam logic [PtrW-1:0] PtrLast     = PtrW'(FifoDepth - 1);
  localparam logic [OccW-1:0] OccFull     = OccW'(FifoDepth);

  if (BaudCycles < 4) begin : g_bad_baud
    $error("oclib_uart_rx: BaudCycles must be >= 4");
  end
  if (SyncCycles < 2) begin : g_bad_sync
    $error("oclib_uart_rx: SyncCycles must be >= 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  logic [SyncCycles-1:0] sync_q, sync_d;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  fe_q, fe_d;
  logic                  ovf_q, ovf_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic [7:0]            mem_q [FifoDepth];

  logic rx_sync;
  logic in_ready;
  logic push;
  logic pop;

  assign rx_sync = sync_q[SyncCycles-1];
  assign sync_d  = {sync_q[SyncCycles-2:0], rx};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    ovf_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (!rx_sync) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntBitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        // Leaving at the stop mid-sample lets an immediately following start bit be seen.
        if (cnt_q == CntBitLast) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = StIdle;
            if (in_ready) push  = 1'b1;
            else          ovf_d = 1'b1;
          end else begin
            fe_d    = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = cnt_q;
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready = (occ_q != OccFull);
  assign rxValid  = (occ_q != '0);
  assign rxData   = mem_q[rd_ptr_q];
  assign pop      = rxValid && rxReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      sync_q   <= '1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      fe_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      fe_q     <= fe_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign framingError = fe_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_oclib_uart_rx.sv
// Directed bench for oclib_uart_rx: frame-level model of expected bytes and
// error pulses, checked every cycle against the selected receiver instance.
`timescale 1ns/1ns
module tb_oclib_uart_rx;

  localparam int unsigned Depth = 4;

  logic       clock = 1'b0;
  logic       resetN, rxReady, sel;
  logic       rx16, rx32;
  logic [7:0] data16, data32;
  logic       v16, v32, fe16, fe32, ov16, ov32;
  logic [7:0] obs_d;
  logic       obs_v, obs_fe, obs_ov;

  oclib_uart_rx #(.BaudCycles(16), .FifoDepth(Depth), .SyncCycles(3)) dut16 (
    .clock(clock), .resetN(resetN), .rx(rx16), .rxData(data16), .rxValid(v16),
    .rxReady(rxReady), .framingError(fe16), .overflow(ov16));

  oclib_uart_rx #(.BaudCycles(32), .FifoDepth(Depth), .SyncCycles(3)) dut32 (
    .clock(clock), .resetN(resetN), .rx(rx32), .rxData(data32), .rxValid(v32),
    .rxReady(rxReady), .framingError(fe32), .overflow(ov32));

  always #50 clock = ~clock;

  always_comb begin
    obs_d  = sel ? data32 : data16;
    obs_v  = sel ? v32 : v16;
    obs_fe = sel ? fe32 : fe16;
    obs_ov = sel ? ov32 : ov16;
  end

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         occ = 0, exp_fe = 0, exp_ovf = 0, seen_fe = 0, seen_ovf = 0, vcycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  // Frame outcome decided from the line contents and FIFO occupancy alone.
  task automatic model_frame(input logic [7:0] b, input bit stop_high);
    if (!stop_high) exp_fe++;
    else if (occ == Depth) exp_ovf++;
    else begin
      exp_q.push_back(b);
      occ++;
    end
  endtask

  logic       prev_v = 0, prev_rdy = 0, prev_fe = 0, prev_ov = 0, prev_rst = 0;
  logic [7:0] prev_d = '0;

  always @(negedge clock) begin
    if (resetN && prev_rst) begin
      if (prev_v && !prev_rdy) begin
        check("hold_valid", obs_v, 1);
        check("hold_data", obs_d, prev_d);
      end
      if (obs_v) vcycles++;
      if (obs_v && rxReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got 0x%0h expected none", obs_d);
        end else begin
          check("rx_data", obs_d, exp_q.pop_front());
        end
        got.push_back(obs_d);
        occ--;
      end
      if (obs_fe) seen_fe++;
      if (obs_ov) seen_ovf++;
      if (obs_fe || obs_ov) check("err_exclusive", obs_fe & obs_ov, 0);
      if (prev_fe) check("fe_one_cycle", obs_fe, 0);
      if (prev_ov) check("ovf_one_cycle", obs_ov, 0);
    end
    prev_v   = obs_v;
    prev_rdy = rxReady;
    prev_d   = obs_d;
    prev_fe  = obs_fe;
    prev_ov  = obs_ov;
    prev_rst = resetN;
  end

  task automatic set_rx(input logic v);
    if (sel) rx32 = v;
    else     rx16 = v;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clock);
    #13;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_ns, input int stop_ns,
                            input bit stop_high);
    model_frame(b, stop_high);
    set_rx(1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      set_rx(b[i]);
      #(bit_ns);
    end
    set_rx(stop_high);
    #(stop_ns);
    set_rx(1'b1);
  endtask

  task automatic end_test(input string name);
    settle(40);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_fe_count"}, seen_fe, exp_fe);
    check({name, "_ovf_count"}, seen_ovf, exp_ovf);
  endtask

  initial begin
    logic [7:0] b;
    resetN  = 1'b0;
    rxReady = 1'b1;
    rx16    = 1'b1;
    rx32    = 1'b1;
    sel     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_valid16", v16, 0);
    check("reset_fe16", fe16, 0);
    check("reset_ovf16", ov16, 0);
    check("reset_valid32", v32, 0);
    resetN = 1'b1;
    settle(20);
    check("idle_after_reset", v16, 0);

    // Single frame
    vcycles = 0;
    send_frame(8'hA5, 1600, 1600, 1);
    end_test("single");
    check("single_byte", got_at(0), 8'hA5);
    check("single_valid_cycles", vcycles, 1);
    check("single_no_fe", seen_fe, 0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1600, 1600, 1);
    send_frame(8'hFF, 1600, 1600, 1);
    send_frame(8'h5A, 1600, 1600, 1);
    end_test("b2b");
    check("b2b_0", got_at(1), 8'h00);
    check("b2b_1", got_at(2), 8'hFF);
    check("b2b_2", got_at(3), 8'h5A);

    // Short glitch then a real frame
    set_rx(1'b0);
    #500;
    set_rx(1'b1);
    #2000;
    end_test("glitch");
    check("glitch_no_transfer", got.size(), 4);
    send_frame(8'h3C, 1600, 1600, 1);
    end_test("after_glitch");
    check("after_glitch_byte", got_at(4), 8'h3C);

    // Stop bit held low (break), then recovery
    send_frame(8'h55, 1600, 4000, 0);
    #1600;
    send_frame(8'h81, 1600, 1600, 1);
    end_test("break");
    check("break_one_fe", seen_fe, 1);
    check("break_recover", got_at(5), 8'h81);

    // FIFO overflow with consumer stalled, then drain
    @(posedge clock);
    #1 rxReady = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      b = 8'(i);
      send_frame(b, 1600, 1600, 1);
    end
    settle(20);
    check("ovf_two_pulses", seen_ovf, 2);
    check("ovf_valid_held", v16, 1);
    check("ovf_head", data16, 8'h01);
    @(posedge clock);
    #1 rxReady = 1'b1;
    end_test("overflow");
    check("drain_0", got_at(6), 8'h01);
    check("drain_1", got_at(7), 8'h02);
    check("drain_2", got_at(8), 8'h03);
    check("drain_3", got_at(9), 8'h04);
    check("drain_count", got.size(), 10);

    // Reset pulse during data bit 4 of 0xC3
    b = 8'hC3;
    set_rx(1'b0);
    #1600;
    for (int i = 0; i < 4; i++) begin
      set_rx(b[i]);
      #1600;
    end
    set_rx(b[4]);
    #800;
    @(posedge clock);
    #1 resetN = 1'b0;
    @(posedge clock);
    #1 resetN = 1'b1;
    set_rx(1'b1);
    occ = 0;
    end_test("midreset");
    check("midreset_no_transfer", got.size(), 10);
    send_frame(8'h7E, 1600, 1600, 1);
    end_test("after_reset");
    check("after_reset_byte", got_at(10), 8'h7E);

    // +-3% bit period on the BaudCycles=32 receiver
    sel = 1'b1;
    settle(5);
    send_frame(8'h96, 3104, 3104, 1);
    end_test("fast3");
    check("fast3_byte", got_at(11), 8'h96);
    send_frame(8'h96, 3296, 3296, 1);
    end_test("slow3");
    check("slow3_byte", got_at(12), 8'h96);
    check("total_transfers", got.size(), 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oclib_uart_rx.md
Name: oclib_uart_rx

Overview:
UART receiver, 8N1, LSB first. Receive-side partner of the UART transmitter in the serial debug/console path. Synchronizes the asynchronous rx pin, detects the start bit, samples each bit at mid-bit, and pushes completed bytes into an internal oclib_fifo. Bytes leave on a valid/ready stream; framing and overflow errors are flagged.

Parameters:
ClockHz, 100_000_000, input clock frequency in Hz
Baud, 115_200, line rate in bits/s
BaudCycles, ClockHz/Baud, clocks per bit; legal range is >= 4 (elaboration-time check)
FifoDepth, 32, receive FIFO depth in bytes
SyncCycles, 3, flops in the rx input synchronizer (>= 2)

Ports:
clock  input  1  sole clock; all logic is on its rising edge
resetN  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line; idles high
rxData  output  8  received byte (FIFO head)
rxValid  output  1  rxData is valid
rxReady  input  1  consumer accepts; a byte is popped when rxValid && rxReady
framingError  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: good byte dropped because the FIFO was full

Behaviour:
- Reset (resetN=0 at a clock edge): all synchronizer flops = 1; state = StIdle; counters = 0; FIFO emptied; rxValid=0, framingError=0, overflow=0. A partial frame is discarded. No false start may follow reset release while rx is high.
- rxSync is the SyncCycles-deep synchronized rx. Its latency is SyncCycles clocks.
- Baud counter: width $clog2(BaudCycles). It is cleared on every state entry except entry to StIdle.
- States are StIdle, StStart, StData, StStop, StWaitHigh:
  - StIdle: when rxSync==0, clear the counter and go to StStart.
  - StStart: when counter == BaudCycles/2 - 1 (integer division), sample rxSync. If 0, go to StData with bitCounter=0 and the counter cleared. If 1, the event is a glitch: go to StIdle with no output and no error.
  - StData: when counter == BaudCycles-1, sample rxSync into shift[7], shift right, bitCounter+1, and clear the counter. After the 8th sample (bitCounter wraps 7->0), go to StStop.
  - StStop: when counter == BaudCycles-1, sample rxSync.
    - If 1 and the FIFO inReady=1: push the shift register (one-cycle inValid), go to StIdle.
    - If 1 and the FIFO is full: drop the byte, pulse overflow, go to StIdle.
    - If 0: pulse framingError, push nothing, go to StWaitHigh. This covers a break condition.
  - StWaitHigh: stay until rxSync==1, then go to StIdle. A held-low line produces exactly one framingError.
- Sample points are mid-bit relative to the detected falling edge, ±1 clock. The receiver must tolerate a ±3% rate mismatch for BaudCycles >= 16.
- Errors are not sticky. framingError and overflow are never both high. They are registered outputs, high for exactly 1 clock.
- Output stream: rxData/rxValid come straight from the FIFO. rxValid first rises at most 2 clocks after the stop-bit sample edge. rxData is held stable while rxValid && !rxReady. Pop and push in the same cycle are both honoured.
- Back-to-back frames: a start bit that begins immediately after the stop bit is detected, because StIdle is re-entered at the stop mid-sample. No frame is lost.
- rxReady is ignored while the FIFO is empty.

Test Plan (BaudCycles=16, SyncCycles=3, FifoDepth=4 unless noted):
- Single frame 0xA5, rxReady=1 -> exactly one transfer with rxData=0xA5, rxValid high 1 cycle, no error pulses.
- Frames 0x00, 0xFF, 0x5A sent back-to-back with zero idle between them -> three transfers in order 0x00, 0xFF, 0x5A.
- rx pulled low for 5 clocks then high (glitch) -> no transfer, no framingError, state back to StIdle. A following 0x3C is received correctly.
- Frame 0x55 with its stop bit held low for 40 clocks -> exactly one framingError pulse and no push. A following 0x81 is received as 0x81.
- rxReady=0, six good frames 0x01..0x06 -> FIFO holds 0x01..0x04 and overflow pulses twice. Raising rxReady then drains exactly 0x01, 0x02, 0x03, 0x04.
- resetN=0 for 1 clock during data bit 4 of 0xC3, with rx then driven high -> no transfer and no error pulses. The next frame 0x7E is received intact.
- Frame 0x96 at 3% fast and 3% slow bit periods (BaudCycles=32) -> received as 0x96 in both cases.
